// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetches opcode bytes, steps execute cycles, handles stall/branch.
// Optional feature: define ILLEGAL_TRAP_EN to trap on opcodes outside 8'h00..8'h04.
module instr_fetch_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              sys_clock,
  input  logic              rst,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  input  logic              stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [7:0]        ir,
  output logic [2:0]        cycle,
  output logic              exec_valid,
  output logic              halted,
  output logic              illegal
);

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALTED, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
`endif

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [7:0]        ir_n;
  logic [2:0]        cycle_n;

  // Index of the final execute cycle (opcode length minus one).
  function automatic logic [2:0] last_cycle(input logic [7:0] op);
    case (op)
      8'h01:   last_cycle = 3'd1;
      8'h04:   last_cycle = 3'd2;
      default: last_cycle = 3'd0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    cycle_n = cycle;
    case (state)
      IDLE: if (run) state_n = FETCH;
      FETCH: begin
        if (mem_valid) begin
          ir_n    = mem_data;
          pc_n    = pc + ADDR_W'(1);
          cycle_n = '0;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (cycle != last_cycle(ir)) begin
            cycle_n = cycle + 3'd1;
          end else begin
            cycle_n = '0;
            if (pc_load) pc_n = pc_load_addr;
            if (ir == 8'h00) state_n = HALTED;
`ifdef ILLEGAL_TRAP_EN
            else if (ir > 8'h04) state_n = TRAP;
`endif
            else if (run) state_n = FETCH;
            else state_n = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // Status outputs are flops loaded from the next state so they align with it.
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= PC_INIT;
      ir         <= '0;
      cycle      <= '0;
      mem_rd     <= 1'b0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ir         <= ir_n;
      cycle      <= cycle_n;
      mem_rd     <= (state_n == FETCH);
      exec_valid <= (state_n == EXEC);
      halted     <= (state_n == HALTED);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) illegal <= 1'b0;
    else      illegal <= (state_n == TRAP);
  end
`else
  assign illegal = 1'b0;
`endif

  assign mem_addr = pc;

endmodule
